// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// The S_JAL state only exists when JAL_EN is defined.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
`ifdef JAL_EN
      S_JAL      = 4'd10,
`endif
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_DATA      = 2'b01,
      RES_ALURESULT = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'b00,
      SRCA_OLDPC = 2'b01,
      SRCA_RS1   = 2'b10
   } srca_t;

   typedef enum logic [1:0] {
      SRCB_RS2  = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } srcb_t;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_t;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decode from ALUOp/funct fields; flags
// funct3 values the datapath does not implement.
module mc_alu_decoder
   import mc_ctrl_pkg::*;
(
   input  aluop_t     aluop_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       op5_i,
   output logic [2:0] alu_ctrl_o,
   output logic       illegal_o
);

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      illegal_o  = 1'b0;
      case (aluop_i)
         ALUOP_SUB:   alu_ctrl_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               // op5 separates R-type from I-type: addi never subtracts
               3'b000:  alu_ctrl_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_ctrl_o = ALU_SLT;
               3'b110:  alu_ctrl_o = ALU_OR;
               3'b111:  alu_ctrl_o = ALU_AND;
               default: illegal_o  = 1'b1;
            endcase
         end
         default:     alu_ctrl_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM with req/ready memory handshake and
// optional timeout trap. Define JAL_EN to decode jal.
module multicycle_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned ALUCTRL_W   = 3,
   parameter int unsigned MEM_TIMEOUT = 0,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opCode,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 zero,
   input  logic                 memReady,
   output logic                 memReq,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 RegWrite,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ImmSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 illegalInstr,
   output logic                 busError,
   output logic [3:0]           stateDbg
);

   localparam bit             TO_EN  = (MEM_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TO_EN ? MEM_TIMEOUT - 1 : 0);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ill_q, ill_d;
   logic              berr_q, berr_d;

   logic              req_c, adr_c, mw_c, irw_c, pcw_c, rw_c, wait_c;
   result_src_t       rs_c;
   srca_t             sa_c;
   srcb_t             sb_c;
   aluop_t            aluop_c;
   logic [2:0]        alu_ctrl;
   logic              funct_illegal;

   mc_alu_decoder u_alu_dec (
      .aluop_i    (aluop_c),
      .funct3_i   (funct3),
      .funct7b5_i (funct7b5),
      .op5_i      (opCode[5]),
      .alu_ctrl_o (alu_ctrl),
      .illegal_o  (funct_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
         berr_q  <= berr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      ill_d   = ill_q;
      berr_d  = berr_q;
      req_c   = 1'b0;
      adr_c   = 1'b0;
      mw_c    = 1'b0;
      irw_c   = 1'b0;
      pcw_c   = 1'b0;
      rw_c    = 1'b0;
      wait_c  = 1'b0;
      rs_c    = RES_ALUOUT;
      sa_c    = SRCA_PC;
      sb_c    = SRCB_RS2;
      aluop_c = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            req_c = 1'b1;
            sb_c  = SRCB_FOUR;
            rs_c  = RES_ALURESULT;
            if (memReady) begin
               irw_c   = 1'b1;
               pcw_c   = 1'b1;
               state_d = S_DECODE;
            end else begin
               wait_c  = 1'b1;
            end
         end
         S_DECODE: begin
            sa_c = SRCA_OLDPC;
            sb_c = SRCB_IMM;
            case (opCode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
`ifdef JAL_EN
               OP_JAL:       state_d = S_JAL;
`endif
               default: begin
                  state_d = S_TRAP;
                  ill_d   = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            sa_c    = SRCA_RS1;
            sb_c    = SRCB_IMM;
            state_d = (opCode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            req_c = 1'b1;
            adr_c = 1'b1;
            if (memReady) state_d = S_MEMWB;
            else          wait_c  = 1'b1;
         end
         S_MEMWB: begin
            rs_c    = RES_DATA;
            rw_c    = 1'b1;
            state_d = S_FETCH;
         end
         S_MEMWRITE: begin
            req_c = 1'b1;
            adr_c = 1'b1;
            mw_c  = 1'b1;
            if (memReady) state_d = S_FETCH;
            else          wait_c  = 1'b1;
         end
         S_EXECR, S_EXECI: begin
            sa_c    = SRCA_RS1;
            sb_c    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RS2;
            aluop_c = ALUOP_FUNCT;
            if (funct_illegal) begin
               state_d = S_TRAP;
               ill_d   = 1'b1;
            end else begin
               state_d = S_ALUWB;
            end
         end
         S_ALUWB: begin
            rw_c    = 1'b1;
            state_d = S_FETCH;
         end
         S_BEQ: begin
            sa_c    = SRCA_RS1;
            aluop_c = ALUOP_SUB;
            pcw_c   = zero;
            state_d = S_FETCH;
         end
`ifdef JAL_EN
         S_JAL: begin
            sa_c    = SRCA_OLDPC;
            sb_c    = SRCB_FOUR;
            pcw_c   = 1'b1;
            state_d = S_ALUWB;
         end
`endif
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
      // Timeout only applies while stalled; memReady in the last cycle wins
      if (wait_c) begin
         if (TO_EN && (cnt_q == TO_LIM)) begin
            state_d = S_TRAP;
            berr_d  = 1'b1;
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      case (opCode)
         OP_SW:   ImmSrc = IMM_S;
         OP_BEQ:  ImmSrc = IMM_B;
`ifdef JAL_EN
         OP_JAL:  ImmSrc = IMM_J;
`endif
         default: ImmSrc = IMM_I;
      endcase
   end

   // Strobes are gated so nothing fires while reset is held
   assign memReq       = req_c & rst_n;
   assign MemWrite     = mw_c  & rst_n;
   assign IRWrite      = irw_c & rst_n;
   assign PCWrite      = pcw_c & rst_n;
   assign RegWrite     = rw_c  & rst_n;
   assign AdrSrc       = adr_c;
   assign ResultSrc    = rs_c;
   assign ALUSrcA      = sa_c;
   assign ALUSrcB      = sb_c;
   assign ALUControl   = ALUCTRL_W'(alu_ctrl);
   assign illegalInstr = ill_q;
   assign busError     = berr_q;
   assign stateDbg     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: driver queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_multicycle_control_unit;
   import mc_ctrl_pkg::*;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;

   typedef struct packed {
      logic [3:0] st;
      logic       req, adr, mw, irw, pcw, rw;
      logic [1:0] rs, sa, sb, imm;
      logic [2:0] alu;
      logic       il, be;
   } obs_t;

   typedef struct {
      obs_t  e;
      string nm;
   } item_t;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic [6:0] opCode = '0;
   logic [2:0] funct3 = '0;
   logic       funct7b5 = 1'b0, zero = 1'b0, memReady = 1'b0;
   logic       memReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic       illegalInstr, busError;
   logic [3:0] stateDbg;

   item_t sb_q[$];
   int    n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.ALUCTRL_W(3), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .opCode(opCode), .funct3(funct3),
      .funct7b5(funct7b5), .zero(zero), .memReady(memReady),
      .memReq(memReq), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegalInstr(illegalInstr),
      .busError(busError), .stateDbg(stateDbg)
   );

   // Expected outputs for a given state, straight from the control table
   function automatic obs_t exp_obs(input state_t st, input logic [6:0] op,
                                    input logic [2:0] f3, input logic f7,
                                    input logic z, input logic mr,
                                    input logic il, input logic be, input logic rn);
      obs_t o;
      o     = '0;
      o.st  = st;
      o.il  = il;
      o.be  = be;
      o.imm = (op == SW) ? 2'b01 : (op == BQ) ? 2'b10 : 2'b00;
`ifdef JAL_EN
      if (op == JL) o.imm = 2'b11;
`endif
      case (st)
         S_FETCH:    begin o.req = 1'b1; o.sb = 2'b10; o.rs = 2'b10; o.irw = mr; o.pcw = mr; end
         S_DECODE:   begin o.sa = 2'b01; o.sb = 2'b01; end
         S_MEMADR:   begin o.sa = 2'b10; o.sb = 2'b01; end
         S_MEMREAD:  begin o.req = 1'b1; o.adr = 1'b1; end
         S_MEMWB:    begin o.rs = 2'b01; o.rw = 1'b1; end
         S_MEMWRITE: begin o.req = 1'b1; o.adr = 1'b1; o.mw = 1'b1; end
         S_EXECR, S_EXECI: begin
            o.sa = 2'b10;
            o.sb = (st == S_EXECI) ? 2'b01 : 2'b00;
            case (f3)
               3'b000:  o.alu = (st == S_EXECR && f7) ? 3'b001 : 3'b000;
               3'b010:  o.alu = 3'b101;
               3'b110:  o.alu = 3'b011;
               3'b111:  o.alu = 3'b010;
               default: o.alu = 3'b000;
            endcase
         end
         S_ALUWB:    o.rw = 1'b1;
         S_BEQ:      begin o.sa = 2'b10; o.alu = 3'b001; o.pcw = z; end
         default:    ;
      endcase
      if (!rn) begin
         o.req = 1'b0; o.mw = 1'b0; o.irw = 1'b0; o.pcw = 1'b0; o.rw = 1'b0;
      end
      return o;
   endfunction

   task automatic cyc(input string nm, input state_t est, input logic [6:0] op,
                      input logic [2:0] f3, input logic f7, input logic z,
                      input logic mr, input logic eil, input logic ebe);
      item_t it;
      opCode = op; funct3 = f3; funct7b5 = f7; zero = z; memReady = mr;
      it.e  = exp_obs(est, op, f3, f7, z, mr, eil, ebe, 1'b1);
      it.nm = nm;
      sb_q.push_back(it);
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input string nm);
      item_t it;
      memReady = 1'b0;
      rst_n    = 1'b0;
      #1;
      it.e  = exp_obs(S_FETCH, opCode, funct3, funct7b5, zero, 1'b0, 1'b0, 1'b0, 1'b0);
      it.nm = nm;
      sb_q.push_back(it);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         item_t it;
         obs_t  got;
         it  = sb_q.pop_front();
         got = '{stateDbg, memReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegalInstr, busError};
         n_chk++;
         if (got !== it.e) begin
            n_fail++;
            $display("FAIL %s: got st=%0d obs=%h, expected st=%0d obs=%h",
                     it.nm, got.st, got, it.e.st, it.e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1;
      do_reset("reset_init");

      // lw: 3 stall cycles in FETCH (4th ready hits the timeout boundary), 2 in MEMREAD
      cyc("lw_f0", S_FETCH, LW, 3'b010, 0, 0, 0, 0, 0);
      cyc("lw_f1", S_FETCH, LW, 3'b010, 0, 0, 0, 0, 0);
      cyc("lw_f2", S_FETCH, LW, 3'b010, 0, 0, 0, 0, 0);
      cyc("lw_f3", S_FETCH, LW, 3'b010, 0, 0, 1, 0, 0);
      cyc("lw_dec", S_DECODE, LW, 3'b010, 0, 0, 0, 0, 0);
      cyc("lw_adr", S_MEMADR, LW, 3'b010, 0, 0, 0, 0, 0);
      cyc("lw_rd0", S_MEMREAD, LW, 3'b010, 0, 0, 0, 0, 0);
      cyc("lw_rd1", S_MEMREAD, LW, 3'b010, 0, 0, 0, 0, 0);
      cyc("lw_rd2", S_MEMREAD, LW, 3'b010, 0, 0, 1, 0, 0);
      cyc("lw_wb", S_MEMWB, LW, 3'b010, 0, 0, 0, 0, 0);

      // R-type sub, addi with funct7b5 set, or, slt, andi
      cyc("sub_f", S_FETCH, RT, 3'b000, 1, 0, 1, 0, 0);
      cyc("sub_dec", S_DECODE, RT, 3'b000, 1, 0, 0, 0, 0);
      cyc("sub_ex", S_EXECR, RT, 3'b000, 1, 0, 0, 0, 0);
      cyc("sub_wb", S_ALUWB, RT, 3'b000, 1, 0, 0, 0, 0);
      cyc("addi_f", S_FETCH, IT, 3'b000, 1, 0, 1, 0, 0);
      cyc("addi_dec", S_DECODE, IT, 3'b000, 1, 0, 0, 0, 0);
      cyc("addi_ex", S_EXECI, IT, 3'b000, 1, 0, 0, 0, 0);
      cyc("addi_wb", S_ALUWB, IT, 3'b000, 1, 0, 0, 0, 0);
      cyc("or_f", S_FETCH, RT, 3'b110, 0, 0, 1, 0, 0);
      cyc("or_dec", S_DECODE, RT, 3'b110, 0, 0, 0, 0, 0);
      cyc("or_ex", S_EXECR, RT, 3'b110, 0, 0, 0, 0, 0);
      cyc("or_wb", S_ALUWB, RT, 3'b110, 0, 0, 0, 0, 0);
      cyc("slt_f", S_FETCH, RT, 3'b010, 0, 0, 1, 0, 0);
      cyc("slt_dec", S_DECODE, RT, 3'b010, 0, 0, 0, 0, 0);
      cyc("slt_ex", S_EXECR, RT, 3'b010, 0, 0, 0, 0, 0);
      cyc("slt_wb", S_ALUWB, RT, 3'b010, 0, 0, 0, 0, 0);
      cyc("andi_f", S_FETCH, IT, 3'b111, 0, 0, 1, 0, 0);
      cyc("andi_dec", S_DECODE, IT, 3'b111, 0, 0, 0, 0, 0);
      cyc("andi_ex", S_EXECI, IT, 3'b111, 0, 0, 0, 0, 0);
      cyc("andi_wb", S_ALUWB, IT, 3'b111, 0, 0, 0, 0, 0);

      // beq taken and not taken
      cyc("beq1_f", S_FETCH, BQ, 3'b000, 0, 0, 1, 0, 0);
      cyc("beq1_dec", S_DECODE, BQ, 3'b000, 0, 1, 0, 0, 0);
      cyc("beq1_ex", S_BEQ, BQ, 3'b000, 0, 1, 0, 0, 0);
      cyc("beq0_f", S_FETCH, BQ, 3'b000, 0, 0, 1, 0, 0);
      cyc("beq0_dec", S_DECODE, BQ, 3'b000, 0, 0, 0, 0, 0);
      cyc("beq0_ex", S_BEQ, BQ, 3'b000, 0, 0, 0, 0, 0);

      // sw with one stall, then a second sw reset mid-MEMWRITE
      cyc("sw_f", S_FETCH, SW, 3'b010, 0, 0, 1, 0, 0);
      cyc("sw_dec", S_DECODE, SW, 3'b010, 0, 0, 0, 0, 0);
      cyc("sw_adr", S_MEMADR, SW, 3'b010, 0, 0, 0, 0, 0);
      cyc("sw_w0", S_MEMWRITE, SW, 3'b010, 0, 0, 0, 0, 0);
      cyc("sw_w1", S_MEMWRITE, SW, 3'b010, 0, 0, 1, 0, 0);
      cyc("sw2_f", S_FETCH, SW, 3'b010, 0, 0, 1, 0, 0);
      cyc("sw2_dec", S_DECODE, SW, 3'b010, 0, 0, 0, 0, 0);
      cyc("sw2_adr", S_MEMADR, SW, 3'b010, 0, 0, 0, 0, 0);
      cyc("sw2_w0", S_MEMWRITE, SW, 3'b010, 0, 0, 0, 0, 0);
      do_reset("reset_mid_memwrite");

      // illegal funct3 in EXECR traps on the following cycle
      cyc("badf3_f", S_FETCH, RT, 3'b001, 0, 0, 1, 0, 0);
      cyc("badf3_dec", S_DECODE, RT, 3'b001, 0, 0, 0, 0, 0);
      cyc("badf3_ex", S_EXECR, RT, 3'b001, 0, 0, 0, 0, 0);
      cyc("badf3_trap", S_TRAP, RT, 3'b001, 0, 0, 1, 1, 0);
      do_reset("reset_after_badf3");

      // opcode 0 traps and stays put regardless of memReady
      cyc("op0_f", S_FETCH, 7'd0, 3'b000, 0, 0, 1, 0, 0);
      cyc("op0_dec", S_DECODE, 7'd0, 3'b000, 0, 0, 0, 0, 0);
      for (int unsigned i = 0; i < 4; i++)
         cyc("op0_trap", S_TRAP, 7'd0, 3'b000, 0, i[0], i[0], 1, 0);
      do_reset("reset_after_op0");

`ifndef JAL_EN
      cyc("jal_f", S_FETCH, JL, 3'b000, 0, 0, 1, 0, 0);
      cyc("jal_dec", S_DECODE, JL, 3'b000, 0, 0, 0, 0, 0);
      cyc("jal_trap", S_TRAP, JL, 3'b000, 0, 0, 0, 1, 0);
      do_reset("reset_after_jal");
`endif

      // FETCH timeout: four stalled cycles then TRAP with busError
      for (int unsigned i = 0; i < 4; i++)
         cyc("to_fetch_wait", S_FETCH, LW, 3'b010, 0, 0, 0, 0, 0);
      cyc("to_fetch_trap", S_TRAP, LW, 3'b010, 0, 0, 1, 0, 1);
      do_reset("reset_after_to_fetch");

      // MEMREAD timeout
      cyc("to_rd_f", S_FETCH, LW, 3'b010, 0, 0, 1, 0, 0);
      cyc("to_rd_dec", S_DECODE, LW, 3'b010, 0, 0, 0, 0, 0);
      cyc("to_rd_adr", S_MEMADR, LW, 3'b010, 0, 0, 0, 0, 0);
      for (int unsigned i = 0; i < 4; i++)
         cyc("to_rd_wait", S_MEMREAD, LW, 3'b010, 0, 0, 0, 0, 0);
      cyc("to_rd_trap", S_TRAP, LW, 3'b010, 0, 0, 0, 0, 1);
      do_reset("reset_after_to_rd");
      cyc("post_reset_fetch", S_FETCH, LW, 3'b010, 0, 0, 0, 0, 0);

      for (int unsigned i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
      if (sb_q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
